// File: rtl/riscv_id.sv
// RV32I decode stage: register file, immediate generation and
// control decode, registered into the ID/EX boundary.
//
// Ports:
//   clk_i, rst_i                    clock, async active-high reset
//   PC_IF_i, instr_IF_i             PC and instruction from IF/ID
//   stall_i, flush_i                hold / bubble the ID/EX register
//   reg_write_WB_i, rd_WB_i,
//   rd_data_WB_i                    write-back port into the regfile
//   PC_ID_o .. funct7b5_o           registered data to EX
//   alu_src_o .. auipc_o            registered controls to EX
//   illegal_o                       registered unsupported-opcode flag
module riscv_id #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic [XLEN-1:0] PC_IF_i,
  input  logic [XLEN-1:0] instr_IF_i,
  input  logic            stall_i,
  input  logic            flush_i,
  input  logic            reg_write_WB_i,
  input  logic [4:0]      rd_WB_i,
  input  logic [XLEN-1:0] rd_data_WB_i,
  output logic [XLEN-1:0] PC_ID_o,
  output logic [XLEN-1:0] rs1_data_o,
  output logic [XLEN-1:0] rs2_data_o,
  output logic [XLEN-1:0] imm_o,
  output logic [4:0]      rs1_o,
  output logic [4:0]      rs2_o,
  output logic [4:0]      rd_o,
  output logic [2:0]      funct3_o,
  output logic            funct7b5_o,
  output logic            alu_src_o,
  output logic            reg_write_o,
  output logic            mem_read_o,
  output logic            mem_write_o,
  output logic            branch_o,
  output logic            jal_o,
  output logic            jalr_o,
  output logic            lui_o,
  output logic            auipc_o,
  output logic            illegal_o
);

  localparam int AW = $clog2(NREGS);

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_OP     = 7'b0110011;

  logic [XLEN-1:0] rf [NREGS];

  logic [6:0]      opcode;
  logic [4:0]      rs1;
  logic [4:0]      rs2;
  logic [4:0]      rd;
  logic [XLEN-1:0] rs1_data;
  logic [XLEN-1:0] rs2_data;
  logic            wb_en;

  assign opcode = instr_IF_i[6:0];
  assign rs1    = instr_IF_i[19:15];
  assign rs2    = instr_IF_i[24:20];
  assign wb_en  = reg_write_WB_i && (rd_WB_i != 5'd0);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < NREGS; i++) begin
        rf[i] <= '0;
      end
    end else if (wb_en) begin
      rf[rd_WB_i[AW-1:0]] <= rd_data_WB_i;
    end
  end

  // x0 is hard zero; a same-cycle write-back wins over the stale entry.
  always_comb begin
    rs1_data = rf[rs1[AW-1:0]];
    if (rs1 == 5'd0) begin
      rs1_data = '0;
    end else if (wb_en && rd_WB_i == rs1) begin
      rs1_data = rd_data_WB_i;
    end
  end

  always_comb begin
    rs2_data = rf[rs2[AW-1:0]];
    if (rs2 == 5'd0) begin
      rs2_data = '0;
    end else if (wb_en && rd_WB_i == rs2) begin
      rs2_data = rd_data_WB_i;
    end
  end

  logic [XLEN-1:0] imm_i;
  logic [XLEN-1:0] imm_s;
  logic [XLEN-1:0] imm_b;
  logic [XLEN-1:0] imm_u;
  logic [XLEN-1:0] imm_j;
  logic            sgn;

  assign sgn   = instr_IF_i[31];
  assign imm_i = {{(XLEN-12){sgn}}, instr_IF_i[31:20]};
  assign imm_s = {{(XLEN-12){sgn}}, instr_IF_i[31:25],
                  instr_IF_i[11:7]};
  assign imm_b = {{(XLEN-12){sgn}}, instr_IF_i[7],
                  instr_IF_i[30:25], instr_IF_i[11:8], 1'b0};
  assign imm_u = {{(XLEN-32){sgn}}, instr_IF_i[31:12], 12'd0};
  assign imm_j = {{(XLEN-20){sgn}}, instr_IF_i[19:12],
                  instr_IF_i[20], instr_IF_i[30:21], 1'b0};

  logic [XLEN-1:0] imm;
  logic [4:0]      rd_dec;
  logic            alu_src;
  logic            reg_write;
  logic            mem_read;
  logic            mem_write;
  logic            branch;
  logic            jal;
  logic            jalr;
  logic            lui;
  logic            auipc;
  logic            illegal;

  assign rd = instr_IF_i[11:7];

  always_comb begin
    imm       = '0;
    rd_dec    = rd;
    alu_src   = 1'b0;
    reg_write = 1'b0;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    branch    = 1'b0;
    jal       = 1'b0;
    jalr      = 1'b0;
    lui       = 1'b0;
    auipc     = 1'b0;
    illegal   = 1'b0;
    case (opcode)
      OP_LUI: begin
        imm = imm_u;
        reg_write = 1'b1;
        lui = 1'b1;
        alu_src = 1'b1;
      end
      OP_AUIPC: begin
        imm = imm_u;
        reg_write = 1'b1;
        auipc = 1'b1;
        alu_src = 1'b1;
      end
      OP_JAL: begin
        imm = imm_j;
        reg_write = 1'b1;
        jal = 1'b1;
      end
      OP_JALR: begin
        imm = imm_i;
        reg_write = 1'b1;
        jalr = 1'b1;
        alu_src = 1'b1;
      end
      OP_BRANCH: begin
        imm = imm_b;
        rd_dec = 5'd0;
        branch = 1'b1;
      end
      OP_LOAD: begin
        imm = imm_i;
        reg_write = 1'b1;
        mem_read = 1'b1;
        alu_src = 1'b1;
      end
      OP_STORE: begin
        imm = imm_s;
        rd_dec = 5'd0;
        mem_write = 1'b1;
        alu_src = 1'b1;
      end
      OP_IMM: begin
        imm = imm_i;
        reg_write = 1'b1;
        alu_src = 1'b1;
      end
      OP_OP: begin
        reg_write = 1'b1;
      end
      default: begin
        illegal = 1'b1;
      end
    endcase
  end

  // Flush beats stall; a flushed slot still captures the data fields so
  // the bubble's payload is deterministic.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      PC_ID_o     <= '0;
      rs1_data_o  <= '0;
      rs2_data_o  <= '0;
      imm_o       <= '0;
      rs1_o       <= '0;
      rs2_o       <= '0;
      rd_o        <= '0;
      funct3_o    <= '0;
      funct7b5_o  <= 1'b0;
      alu_src_o   <= 1'b0;
      reg_write_o <= 1'b0;
      mem_read_o  <= 1'b0;
      mem_write_o <= 1'b0;
      branch_o    <= 1'b0;
      jal_o       <= 1'b0;
      jalr_o      <= 1'b0;
      lui_o       <= 1'b0;
      auipc_o     <= 1'b0;
      illegal_o   <= 1'b0;
    end else if (flush_i || !stall_i) begin
      PC_ID_o     <= PC_IF_i;
      rs1_data_o  <= rs1_data;
      rs2_data_o  <= rs2_data;
      imm_o       <= imm;
      rs1_o       <= rs1;
      rs2_o       <= rs2;
      rd_o        <= rd_dec;
      funct3_o    <= instr_IF_i[14:12];
      funct7b5_o  <= instr_IF_i[30];
      alu_src_o   <= alu_src   && !flush_i;
      reg_write_o <= reg_write && !flush_i;
      mem_read_o  <= mem_read  && !flush_i;
      mem_write_o <= mem_write && !flush_i;
      branch_o    <= branch    && !flush_i;
      jal_o       <= jal       && !flush_i;
      jalr_o      <= jalr      && !flush_i;
      lui_o       <= lui       && !flush_i;
      auipc_o     <= auipc     && !flush_i;
      illegal_o   <= illegal   && !flush_i;
    end
  end

endmodule

// File: tb/tb_riscv_id.sv
// Directed self-checking bench for riscv_id.
// One task per scenario, hand-computed expected values.
module tb_riscv_id;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic [31:0] PC_IF_i;
  logic [31:0] instr_IF_i;
  logic        stall_i;
  logic        flush_i;
  logic        reg_write_WB_i;
  logic [4:0]  rd_WB_i;
  logic [31:0] rd_data_WB_i;
  logic [31:0] PC_ID_o;
  logic [31:0] rs1_data_o;
  logic [31:0] rs2_data_o;
  logic [31:0] imm_o;
  logic [4:0]  rs1_o;
  logic [4:0]  rs2_o;
  logic [4:0]  rd_o;
  logic [2:0]  funct3_o;
  logic        funct7b5_o;
  logic        alu_src_o;
  logic        reg_write_o;
  logic        mem_read_o;
  logic        mem_write_o;
  logic        branch_o;
  logic        jal_o;
  logic        jalr_o;
  logic        lui_o;
  logic        auipc_o;
  logic        illegal_o;

  int errors = 0;
  int checks = 0;

  riscv_id dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .PC_IF_i(PC_IF_i), .instr_IF_i(instr_IF_i),
    .stall_i(stall_i), .flush_i(flush_i),
    .reg_write_WB_i(reg_write_WB_i), .rd_WB_i(rd_WB_i),
    .rd_data_WB_i(rd_data_WB_i),
    .PC_ID_o(PC_ID_o), .rs1_data_o(rs1_data_o),
    .rs2_data_o(rs2_data_o), .imm_o(imm_o),
    .rs1_o(rs1_o), .rs2_o(rs2_o), .rd_o(rd_o),
    .funct3_o(funct3_o), .funct7b5_o(funct7b5_o),
    .alu_src_o(alu_src_o), .reg_write_o(reg_write_o),
    .mem_read_o(mem_read_o), .mem_write_o(mem_write_o),
    .branch_o(branch_o), .jal_o(jal_o), .jalr_o(jalr_o),
    .lui_o(lui_o), .auipc_o(auipc_o), .illegal_o(illegal_o)
  );

  always #5 clk_i = ~clk_i;

  // Controls packed as {alu_src,reg_write,mem_read,mem_write,
  // branch,jal,jalr,lui,auipc,illegal}.
  logic [9:0] ctl;
  assign ctl = {alu_src_o, reg_write_o, mem_read_o, mem_write_o,
                branch_o, jal_o, jalr_o, lui_o, auipc_o, illegal_o};

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle_inputs();
    stall_i = 1'b0;
    flush_i = 1'b0;
    reg_write_WB_i = 1'b0;
    rd_WB_i = 5'd0;
    rd_data_WB_i = 32'd0;
  endtask

  task automatic test_reset();
    rst_i = 1'b1;
    PC_IF_i = 32'h0000_0100;
    instr_IF_i = 32'h0050_0093;
    idle_inputs();
    step();
    step();
    checks++;
    if (ctl !== 10'd0) begin
      errors++;
      $display("FAIL reset_ctl got %b exp %b", ctl, 10'd0);
    end
    checks++;
    if ({PC_ID_o, imm_o, rs1_data_o} !== 96'd0) begin
      errors++;
      $display("FAIL reset_data got %h exp 0",
               {PC_ID_o, imm_o, rs1_data_o});
    end
    rst_i = 1'b0;
  endtask

  task automatic test_addi();
    PC_IF_i = 32'h0000_0104;
    instr_IF_i = 32'h0050_0093;
    step();
    checks++;
    if (imm_o !== 32'h5 || rd_o !== 5'd1 || rs1_data_o !== 32'd0) begin
      errors++;
      $display("FAIL addi_data got imm=%h rd=%0d rs1d=%h exp 5 1 0",
               imm_o, rd_o, rs1_data_o);
    end
    checks++;
    if (ctl !== 10'b1100000000) begin
      errors++;
      $display("FAIL addi_ctl got %b exp %b", ctl, 10'b1100000000);
    end
    checks++;
    if (PC_ID_o !== 32'h0000_0104) begin
      errors++;
      $display("FAIL addi_pc got %h exp %h", PC_ID_o, 32'h104);
    end
  endtask

  task automatic test_bypass();
    instr_IF_i = 32'h0021_01B3;
    reg_write_WB_i = 1'b1;
    rd_WB_i = 5'd2;
    rd_data_WB_i = 32'hDEAD_BEEF;
    step();
    reg_write_WB_i = 1'b0;
    checks++;
    if (rs1_data_o !== 32'hDEAD_BEEF || rs2_data_o !== 32'hDEAD_BEEF) begin
      errors++;
      $display("FAIL bypass got %h %h exp deadbeef",
               rs1_data_o, rs2_data_o);
    end
    checks++;
    if (rd_o !== 5'd3 || ctl !== 10'b0100000000) begin
      errors++;
      $display("FAIL add_ctl got rd=%0d ctl=%b exp 3 0100000000",
               rd_o, ctl);
    end
    step();
    checks++;
    if (rs1_data_o !== 32'hDEAD_BEEF || rs2_o !== 5'd2) begin
      errors++;
      $display("FAIL rf_read got %h rs2=%0d exp deadbeef 2",
               rs1_data_o, rs2_o);
    end
  endtask

  task automatic test_x0();
    instr_IF_i = 32'h0050_0093;
    reg_write_WB_i = 1'b1;
    rd_WB_i = 5'd0;
    rd_data_WB_i = 32'h1234_5678;
    step();
    checks++;
    if (rs1_data_o !== 32'd0) begin
      errors++;
      $display("FAIL x0_same got %h exp 0", rs1_data_o);
    end
    reg_write_WB_i = 1'b0;
    step();
    checks++;
    if (rs1_data_o !== 32'd0) begin
      errors++;
      $display("FAIL x0_after got %h exp 0", rs1_data_o);
    end
  endtask

  task automatic test_formats();
    instr_IF_i = 32'hFE00_0CE3;
    step();
    checks++;
    if (imm_o !== 32'hFFFF_FFF8 || rd_o !== 5'd0) begin
      errors++;
      $display("FAIL beq got imm=%h rd=%0d exp fffffff8 0", imm_o, rd_o);
    end
    checks++;
    if (ctl !== 10'b0000100000) begin
      errors++;
      $display("FAIL beq_ctl got %b exp 0000100000", ctl);
    end
    instr_IF_i = 32'h0050_A423;
    step();
    checks++;
    if (imm_o !== 32'h8 || rd_o !== 5'd0 || ctl !== 10'b1001000000) begin
      errors++;
      $display("FAIL sw got imm=%h rd=%0d ctl=%b exp 8 0 1001000000",
               imm_o, rd_o, ctl);
    end
    instr_IF_i = 32'h0080_00EF;
    step();
    checks++;
    if (imm_o !== 32'h8 || rd_o !== 5'd1 || ctl !== 10'b0100010000) begin
      errors++;
      $display("FAIL jal got imm=%h rd=%0d ctl=%b exp 8 1 0100010000",
               imm_o, rd_o, ctl);
    end
  endtask

  task automatic test_flush();
    instr_IF_i = 32'h1234_52B7;
    flush_i = 1'b1;
    step();
    checks++;
    if (ctl !== 10'd0) begin
      errors++;
      $display("FAIL flush_ctl got %b exp 0", ctl);
    end
    flush_i = 1'b0;
    step();
    checks++;
    if (imm_o !== 32'h1234_5000 || rd_o !== 5'd5) begin
      errors++;
      $display("FAIL lui got imm=%h rd=%0d exp 12345000 5", imm_o, rd_o);
    end
    checks++;
    if (ctl !== 10'b1100000100) begin
      errors++;
      $display("FAIL lui_ctl got %b exp 1100000100", ctl);
    end
    flush_i = 1'b1;
    stall_i = 1'b1;
    step();
    checks++;
    if (ctl !== 10'd0) begin
      errors++;
      $display("FAIL flush_over_stall got %b exp 0", ctl);
    end
    idle_inputs();
  endtask

  task automatic test_stall_reset();
    PC_IF_i = 32'h0000_0200;
    instr_IF_i = 32'hFFFF_FFFF;
    step();
    checks++;
    if (ctl !== 10'b0000000001) begin
      errors++;
      $display("FAIL illegal got %b exp 0000000001", ctl);
    end
    stall_i = 1'b1;
    reg_write_WB_i = 1'b1;
    rd_WB_i = 5'd7;
    rd_data_WB_i = 32'hA5A5_0007;
    for (int i = 0; i < 3; i++) begin
      PC_IF_i = 32'h0000_0300 + 32'(i * 4);
      instr_IF_i = (i == 0) ? 32'h0050_0093 :
                   (i == 1) ? 32'h1234_52B7 : 32'hFE00_0CE3;
      step();
      reg_write_WB_i = 1'b0;
      checks++;
      if (ctl !== 10'b0000000001 || PC_ID_o !== 32'h0000_0200) begin
        errors++;
        $display("FAIL stall_hold%0d got ctl=%b pc=%h exp 1 200",
                 i, ctl, PC_ID_o);
      end
    end
    // ADDI x1,x7,0 during stall release reads x7 written while stalled
    instr_IF_i = 32'h0003_8093;
    stall_i = 1'b0;
    step();
    checks++;
    if (rs1_data_o !== 32'hA5A5_0007) begin
      errors++;
      $display("FAIL stall_wb got %h exp a5a50007", rs1_data_o);
    end
    stall_i = 1'b1;
    instr_IF_i = 32'hFFFF_FFFF;
    #2;
    rst_i = 1'b1;
    #1;
    checks++;
    if (ctl !== 10'd0 || rs1_data_o !== 32'd0 || PC_ID_o !== 32'd0 ||
        imm_o !== 32'd0 || rs1_o !== 5'd0 || rd_o !== 5'd0) begin
      errors++;
      $display("FAIL async_rst got ctl=%b rs1d=%h pc=%h",
               ctl, rs1_data_o, PC_ID_o);
    end
    step();
    rst_i = 1'b0;
    stall_i = 1'b0;
    instr_IF_i = 32'h0003_8093;
    step();
    checks++;
    if (rs1_data_o !== 32'd0) begin
      errors++;
      $display("FAIL rf_cleared got %h exp 0", rs1_data_o);
    end
  endtask

  initial begin
    test_reset();
    test_addi();
    test_bypass();
    test_x0();
    test_formats();
    test_flush();
    test_stall_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
